// File: rtl/butterfly_pkg.sv
// Shared types for the butterfly sequencer: state codes, strobe bundle, and
// the Moore output decode used by the top-level register stage.
package butterfly_pkg;
  localparam int CNT_W = 8;

  typedef enum logic [4:0] {
    WAIT_W = 5'd0,  ST_W   = 5'd1,  WAIT_B = 5'd2,  ST_B   = 5'd3,
    C_REWB = 5'd4,  C_IMY  = 5'd5,  C_IMZ  = 5'd6,  WAIT_A = 5'd7,
    ST_A   = 5'd8,  C_REZ2 = 5'd9,  C_REZ  = 5'd10, C_REY  = 5'd11,
    D_REY  = 5'd12, D_IMY  = 5'd13, D_REZ  = 5'd14, D_IMZ  = 5'd15,
    CLR    = 5'd16
  } bfly_state_t;

  typedef struct packed {
    logic store_W, store_B, store_A;
    logic calc_ReWB, calc_ImY, calc_ImZ, calc_ReZ2, calc_ReZ, calc_ReY;
    logic display_ReY, display_ImY, display_ReZ, display_ImZ;
    logic clear, busy;
  } bfly_ctl_t;

  function automatic logic is_calc(bfly_state_t s);
    return s inside {C_REWB, C_IMY, C_IMZ, C_REZ2, C_REZ, C_REY};
  endfunction

  function automatic logic is_disp(bfly_state_t s);
    return s inside {D_REY, D_IMY, D_REZ, D_IMZ};
  endfunction

  function automatic bfly_ctl_t decode(bfly_state_t s);
    bfly_ctl_t c;
    c = '0;
    case (s)
      ST_W:    c.store_W     = 1'b1;
      ST_B:    c.store_B     = 1'b1;
      ST_A:    c.store_A     = 1'b1;
      C_REWB:  c.calc_ReWB   = 1'b1;
      C_IMY:   c.calc_ImY    = 1'b1;
      C_IMZ:   c.calc_ImZ    = 1'b1;
      C_REZ2:  c.calc_ReZ2   = 1'b1;
      C_REZ:   c.calc_ReZ    = 1'b1;
      C_REY:   c.calc_ReY    = 1'b1;
      D_REY:   c.display_ReY = 1'b1;
      D_IMY:   c.display_ImY = 1'b1;
      D_REZ:   c.display_ReZ = 1'b1;
      D_IMZ:   c.display_ImZ = 1'b1;
      CLR:     c.clear       = 1'b1;
      default: c = '0;
    endcase
    c.busy = is_calc(s);
    return c;
  endfunction
endpackage

// File: rtl/butterfly_sequencer_rise_detect.sv
// Rising-edge detector on a synchronous level. The history register resets
// high so a level already asserted at reset release is not seen as an edge.
module rise_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic in,
  output logic pulse
);
  logic in_q;

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) in_q <= 1'b1;
    else       in_q <= in;

  assign pulse = in & ~in_q;
endmodule

// File: rtl/butterfly_sequencer.sv
// Moore sequencer for the FFT butterfly datapath: operand entry, stretched
// calc strobes, display stepping (manual or timed) and clear.
module butterfly_sequencer
  import butterfly_pkg::*;
#(
  parameter int CALC_CYCLES = 1,
  parameter int DISP_CYCLES = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ReadyIn,
  input  logic       abort,
  output logic       store_W,
  output logic       store_B,
  output logic       store_A,
  output logic       calc_ReWB,
  output logic       calc_ImY,
  output logic       calc_ImZ,
  output logic       calc_ReZ2,
  output logic       calc_ReZ,
  output logic       calc_ReY,
  output logic       display_ReY,
  output logic       display_ImY,
  output logic       display_ReZ,
  output logic       display_ImZ,
  output logic       clear,
  output logic       busy,
  output logic [4:0] step
);
  if (CALC_CYCLES < 1 || CALC_CYCLES > 255) begin : g_bad_calc
    $error("butterfly_sequencer: CALC_CYCLES must be in 1..255");
  end
  if (DISP_CYCLES < 0 || DISP_CYCLES > 255) begin : g_bad_disp
    $error("butterfly_sequencer: DISP_CYCLES must be in 0..255");
  end

  // Counter holds "cycles remaining after this one", so terminal count is 0.
  localparam logic [CNT_W-1:0] CALC_LD   = CNT_W'(CALC_CYCLES - 1);
  localparam logic [CNT_W-1:0] DISP_LD   = (DISP_CYCLES > 0) ? CNT_W'(DISP_CYCLES - 1) : '0;
  localparam bit               AUTO_DISP = (DISP_CYCLES > 0);

  logic             rdy_edge;
  bfly_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       succ;
  logic             cnt_done;
  bfly_ctl_t        ctl_q;

  rise_detect u_rise (
    .Clock (Clock),
    .Reset (Reset),
    .in    (ReadyIn),
    .pulse (rdy_edge)
  );

  assign succ     = state_q + 5'd1;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_W, WAIT_B, WAIT_A:
        if (rdy_edge) state_d = bfly_state_t'(succ);
      ST_W, ST_B, ST_A:
        state_d = bfly_state_t'(succ);
      C_REWB, C_IMY, C_IMZ, C_REZ2, C_REZ, C_REY:
        if (cnt_done) state_d = bfly_state_t'(succ);
      D_REY, D_IMY, D_REZ:
        if (rdy_edge || (AUTO_DISP && cnt_done)) state_d = bfly_state_t'(succ);
      D_IMZ:
        if (rdy_edge) state_d = CLR;
      default:
        state_d = WAIT_W;
    endcase
    if (abort) state_d = CLR;
  end

  // Reload on every state change so an early display advance restarts timing.
  always_comb begin
    cnt_d = cnt_done ? cnt_q : cnt_q - CNT_W'(1);
    if (state_d != state_q) begin
      if (is_calc(state_d))      cnt_d = CALC_LD;
      else if (is_disp(state_d)) cnt_d = DISP_LD;
    end
  end

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state_q <= WAIT_W;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= decode(state_d);
    end

  assign store_W     = ctl_q.store_W;
  assign store_B     = ctl_q.store_B;
  assign store_A     = ctl_q.store_A;
  assign calc_ReWB   = ctl_q.calc_ReWB;
  assign calc_ImY    = ctl_q.calc_ImY;
  assign calc_ImZ    = ctl_q.calc_ImZ;
  assign calc_ReZ2   = ctl_q.calc_ReZ2;
  assign calc_ReZ    = ctl_q.calc_ReZ;
  assign calc_ReY    = ctl_q.calc_ReY;
  assign display_ReY = ctl_q.display_ReY;
  assign display_ImY = ctl_q.display_ImY;
  assign display_ReZ = ctl_q.display_ReZ;
  assign display_ImZ = ctl_q.display_ImZ;
  assign clear       = ctl_q.clear;
  assign busy        = ctl_q.busy;
  assign step        = state_q;
endmodule
